// File: rtl/vga_scope_renderer.sv
// Multi-channel VGA oscilloscope renderer: VGA timing, one circular sample buffer
// holding one word per screen column, and on-the-fly trace/grid drawing.
module vga_scope_renderer #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33,
    parameter int SAMPLE_W  = 8,
    parameter int NUM_CH    = 2,
    parameter int GRID_PX   = 64
) (
    input  logic                         clk_25MHz,
    input  logic                         rst_n,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [NUM_CH*SAMPLE_W-1:0]   s_data,
    input  logic [1:0]                   mode,
    input  logic [NUM_CH-1:0]            ch_enable,
    output logic                         Hsynq,
    output logic                         Vsynq,
    output logic [3:0]                   Red,
    output logic [3:0]                   Green,
    output logic [3:0]                   Blue,
    output logic                         frame_start,
    output logic                         buf_full
);

    localparam int H_ACT = H_SYNC + H_BACK;
    localparam int V_ACT = V_SYNC + V_BACK;
    localparam int H_TOT = H_ACT + H_VISIBLE + H_FRONT;
    localparam int V_TOT = V_ACT + V_VISIBLE + V_FRONT;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);
    localparam int AW    = (H_VISIBLE > 1) ? $clog2(H_VISIBLE) : 1;
    localparam int FW    = $clog2(H_VISIBLE + 1);
    localparam int RW    = (V_VISIBLE > 1) ? $clog2(V_VISIBLE) : 1;
    localparam int DW    = NUM_CH * SAMPLE_W;
    localparam int PW    = SAMPLE_W + RW + 1;

    typedef enum logic [1:0] {
        MODE_ROLL     = 2'd0,
        MODE_FREEZE   = 2'd1,
        MODE_SINGLE   = 2'd2,
        MODE_FREEZE_B = 2'd3
    } mode_e;

    function automatic logic [RW-1:0] row_of(input logic [SAMPLE_W-1:0] s);
        logic [PW-1:0] prod;
        prod = PW'(s) * PW'(V_VISIBLE);
        return RW'(V_VISIBLE - 1) - RW'(prod >> SAMPLE_W);
    endfunction

    function automatic logic [11:0] ch_colour(input int k);
        case (k)
            0:       return 12'h0F0;
            1:       return 12'hFF0;
            2:       return 12'h0FF;
            default: return 12'hF0F;
        endcase
    endfunction

    logic [DW-1:0] col_buf [H_VISIBLE];

    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [FW-1:0] fill_q, fill_d;
    logic [AW-1:0] base_q, base_d;
    mode_e         mode_q, mode_d;
    logic          s_ready_q, s_ready_d;
    logic          buf_full_q, buf_full_d;

    logic [DW-1:0] rd_data_q, rd_data_d;
    logic          s1_vis_q, s1_vis_d;
    logic          s1_draw_q, s1_draw_d;
    logic          s1_first_q, s1_first_d;
    logic [AW-1:0] s1_col_q, s1_col_d;
    logic [RW-1:0] s1_row_q, s1_row_d;
    logic          s1_hs_q, s1_hs_d;
    logic          s1_vs_q, s1_vs_d;
    logic          s1_fs_q, s1_fs_d;

    logic [RW-1:0] y_prev_q [NUM_CH];
    logic [RW-1:0] y_prev_d [NUM_CH];
    logic [RW-1:0] y_cur    [NUM_CH];
    logic [NUM_CH-1:0] lit;
    logic [11:0]   rgb_q, rgb_d;
    logic          hs_q, hs_d;
    logic          vs_q, vs_d;
    logic          fs_q, fs_d;

    logic          h_vis, v_vis, wr_en, entry;
    logic [AW-1:0] col0, rd_addr, wp_base, wr_addr;
    logic [RW-1:0] row0;
    logic [AW:0]   addr_sum;
    logic [FW-1:0] fill_base;
    mode_e         mode_in;

    always_comb begin
        h_d = h_q + 1'b1;
        v_d = v_q;
        if (h_q == HW'(H_TOT - 1)) begin
            h_d = '0;
            v_d = (v_q == VW'(V_TOT - 1)) ? '0 : v_q + 1'b1;
        end
    end

    // Capture path: entering single-shot restarts the buffer, and a handshake on
    // that same cycle is kept as the first captured sample.
    always_comb begin
        mode_in   = mode_e'(mode);
        mode_d    = mode_in;
        entry     = (mode_in == MODE_SINGLE) && (mode_q != MODE_SINGLE);
        wr_en     = s_valid && s_ready_q;
        wp_base   = entry ? '0 : wp_q;
        fill_base = entry ? '0 : fill_q;
        wr_addr   = wp_base;
        wp_d      = wp_base;
        fill_d    = fill_base;
        if (wr_en) begin
            wp_d = (wp_base == AW'(H_VISIBLE - 1)) ? '0 : wp_base + 1'b1;
            if (fill_base != FW'(H_VISIBLE)) begin
                fill_d = fill_base + 1'b1;
            end
        end
        buf_full_d = (mode_in == MODE_SINGLE) && (fill_d == FW'(H_VISIBLE));
        case (mode_in)
            MODE_ROLL:   s_ready_d = 1'b1;
            MODE_SINGLE: s_ready_d = !buf_full_d;
            default:     s_ready_d = 1'b0;
        endcase
    end

    // The display base only moves at the very start of a frame so a frame is never torn.
    always_comb begin
        base_d = base_q;
        if (h_q == '0 && v_q == '0) begin
            case (mode_in)
                MODE_ROLL:   base_d = (fill_q == FW'(H_VISIBLE)) ? wp_q : '0;
                MODE_SINGLE: base_d = '0;
                default:     base_d = base_q;
            endcase
        end
    end

    always_comb begin
        h_vis      = (32'(h_q) >= H_ACT) && (32'(h_q) < H_ACT + H_VISIBLE);
        v_vis      = (32'(v_q) >= V_ACT) && (32'(v_q) < V_ACT + V_VISIBLE);
        col0       = AW'(32'(h_q) - 32'(H_ACT));
        row0       = RW'(32'(v_q) - 32'(V_ACT));
        addr_sum   = (AW+1)'(base_q) + (AW+1)'(col0);
        rd_addr    = (addr_sum >= (AW+1)'(H_VISIBLE)) ? AW'(addr_sum - (AW+1)'(H_VISIBLE))
                                                      : AW'(addr_sum);
        rd_data_d  = col_buf[rd_addr];
        s1_vis_d   = h_vis && v_vis;
        s1_draw_d  = FW'(col0) < fill_q;
        s1_first_d = h_vis && (col0 == '0);
        s1_col_d   = col0;
        s1_row_d   = row0;
        s1_hs_d    = 32'(h_q) < H_SYNC;
        s1_vs_d    = 32'(v_q) < V_SYNC;
        s1_fs_d    = (h_q == '0) && (v_q == '0);
    end

    // A channel is lit between its y in the previous column and its y in this one,
    // which joins neighbouring samples into a continuous trace.
    always_comb begin
        logic [RW-1:0] y_ref, lo, hi;
        y_ref = '0;
        lo    = '0;
        hi    = '0;
        lit   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            y_cur[k]    = row_of(rd_data_q[k*SAMPLE_W +: SAMPLE_W]);
            y_ref       = s1_first_q ? y_cur[k] : y_prev_q[k];
            lo          = (y_ref < y_cur[k]) ? y_ref : y_cur[k];
            hi          = (y_ref < y_cur[k]) ? y_cur[k] : y_ref;
            lit[k]      = s1_draw_q && (s1_row_q >= lo) && (s1_row_q <= hi);
            y_prev_d[k] = s1_vis_q ? y_cur[k] : y_prev_q[k];
        end
    end

    always_comb begin
        rgb_d = 12'h000;
        if (s1_vis_q) begin
            if (s1_row_q == RW'(V_VISIBLE / 2)) begin
                rgb_d = 12'h888;
            end else if ((32'(s1_col_q) % GRID_PX == 0) || (32'(s1_row_q) % GRID_PX == 0)) begin
                rgb_d = 12'h333;
            end
            for (int k = NUM_CH - 1; k >= 0; k--) begin
                if (lit[k] && ch_enable[k]) begin
                    rgb_d = ch_colour(k);
                end
            end
        end
        hs_d = s1_hs_q;
        vs_d = s1_vs_q;
        fs_d = s1_fs_q;
    end

    always_ff @(posedge clk_25MHz) begin
        if (wr_en) begin
            col_buf[wr_addr] <= s_data;
        end
    end

    always_ff @(posedge clk_25MHz) begin
        if (!rst_n) begin
            h_q        <= '0;
            v_q        <= '0;
            wp_q       <= '0;
            fill_q     <= '0;
            base_q     <= '0;
            mode_q     <= MODE_ROLL;
            s_ready_q  <= 1'b0;
            buf_full_q <= 1'b0;
            rd_data_q  <= '0;
            s1_vis_q   <= 1'b0;
            s1_draw_q  <= 1'b0;
            s1_first_q <= 1'b0;
            s1_col_q   <= '0;
            s1_row_q   <= '0;
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
            s1_fs_q    <= 1'b0;
            for (int k = 0; k < NUM_CH; k++) begin
                y_prev_q[k] <= '0;
            end
            rgb_q      <= '0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            fs_q       <= 1'b0;
        end else begin
            h_q        <= h_d;
            v_q        <= v_d;
            wp_q       <= wp_d;
            fill_q     <= fill_d;
            base_q     <= base_d;
            mode_q     <= mode_d;
            s_ready_q  <= s_ready_d;
            buf_full_q <= buf_full_d;
            rd_data_q  <= rd_data_d;
            s1_vis_q   <= s1_vis_d;
            s1_draw_q  <= s1_draw_d;
            s1_first_q <= s1_first_d;
            s1_col_q   <= s1_col_d;
            s1_row_q   <= s1_row_d;
            s1_hs_q    <= s1_hs_d;
            s1_vs_q    <= s1_vs_d;
            s1_fs_q    <= s1_fs_d;
            for (int k = 0; k < NUM_CH; k++) begin
                y_prev_q[k] <= y_prev_d[k];
            end
            rgb_q      <= rgb_d;
            hs_q       <= hs_d;
            vs_q       <= vs_d;
            fs_q       <= fs_d;
        end
    end

    assign s_ready     = s_ready_q;
    assign buf_full    = buf_full_q;
    assign Hsynq       = hs_q;
    assign Vsynq       = vs_q;
    assign frame_start = fs_q;
    assign Red         = rgb_q[11:8];
    assign Green       = rgb_q[7:4];
    assign Blue        = rgb_q[3:0];

endmodule
